// File: rtl/rank_change_logger.sv
// Change logger for the running second-largest tracker: every change of
// rank_in becomes a {value, timestamp} record in a small FWFT FIFO.
module rank_change_logger #(
  parameter int DATA_WIDTH  = 32,
  parameter int STAMP_WIDTH = 16,
  parameter int DEPTH       = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clr,
  input  logic [DATA_WIDTH-1:0]  rank_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_value,
  output logic [STAMP_WIDTH-1:0] out_stamp,
  output logic                   full,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // Handshake: a record leaves the FIFO on any edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.

  logic [DATA_WIDTH-1:0]  mem_value_q [DEPTH];
  logic [STAMP_WIDTH-1:0] mem_stamp_q [DEPTH];

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [STAMP_WIDTH-1:0] stamp_q, stamp_d;
  logic [DATA_WIDTH-1:0]  prev_q, prev_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;

  logic empty;
  logic is_full;
  logic evt;
  logic pop;
  logic push;
  logic drop_evt;

  always_comb begin
    empty    = (count_q == '0);
    is_full  = (count_q == FULL_COUNT);
    pop      = !clr && !empty && out_ready;
    evt      = !clr && (rank_in != prev_q);
    // A full FIFO still takes a record when the head leaves on the same edge.
    push     = evt && (!is_full || pop);
    drop_evt = evt && is_full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stamp_d  = stamp_q + STAMP_WIDTH'(1);
    prev_d   = rank_in;
    drop_d   = drop_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      stamp_d  = '0;
      prev_d   = '0;
      drop_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
      if (drop_evt && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stamp_q  <= '0;
      prev_q   <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stamp_q  <= stamp_d;
      prev_q   <= prev_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the read side masks it whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_value_q[wr_ptr_q] <= rank_in;
      mem_stamp_q[wr_ptr_q] <= stamp_q;
    end
  end

  assign out_valid  = !empty;
  assign full       = is_full;
  assign drop_count = drop_q;
  assign out_value  = empty ? '0 : mem_value_q[rd_ptr_q];
  assign out_stamp  = empty ? '0 : mem_stamp_q[rd_ptr_q];

endmodule

// File: tb/tb_rank_change_logger.sv
// Bench for rank_change_logger: directed scenarios then random traffic,
// each cycle compared against a queue-based reference of the logger.
module tb_rank_change_logger;

  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int DEP = 8;
  localparam int CW  = 2;

  logic          clk;
  logic          resetn;
  logic          clr;
  logic [DW-1:0] rank_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_value;
  logic [SW-1:0] out_stamp;
  logic          full;
  logic [CW-1:0] drop_count;

  rank_change_logger #(
    .DATA_WIDTH (DW),
    .STAMP_WIDTH(SW),
    .DEPTH      (DEP),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (clr),
    .rank_in   (rank_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_stamp (out_stamp),
    .full      (full),
    .drop_count(drop_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: queued records {value, stamp}
  logic [DW+SW-1:0] exp_q[$];
  int               m_stamp;
  logic [DW-1:0]    m_prev;
  int               m_drop;
  int               n_cmp;
  int               n_err;

  task automatic model_reset();
    exp_q.delete();
    m_stamp = 0;
    m_prev  = '0;
    m_drop  = 0;
  endtask

  task automatic model_edge(input logic [DW-1:0] r, input logic rdy, input logic c);
    bit was_full;
    bit popped;
    if (c) begin
      model_reset();
    end else begin
      was_full = (exp_q.size() == DEP);
      popped   = (exp_q.size() > 0) && rdy;
      if (popped) void'(exp_q.pop_front());
      if (r != m_prev) begin
        if (!was_full || popped) exp_q.push_back({r, SW'(m_stamp)});
        else if (m_drop < (1 << CW) - 1) m_drop++;
      end
      m_prev  = r;
      m_stamp = (m_stamp + 1) % (1 << SW);
    end
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [DW+SW-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("out_value", 64'(out_value), 64'(head[DW+SW-1:SW]));
    check("out_stamp", 64'(out_stamp), 64'(head[SW-1:0]));
    check("full", 64'(full), 64'(exp_q.size() == DEP));
    check("drop_count", 64'(drop_count), 64'(m_drop));
  endtask

  // driver: apply inputs, take one edge, update model, sample 1 time unit later
  task automatic step(input logic [DW-1:0] r, input logic rdy, input logic c);
    rank_in   = r;
    out_ready = rdy;
    clr       = c;
    @(posedge clk);
    model_edge(r, rdy, c);
    #1;
    check_all();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    resetn    = 1'b0;
    clr       = 1'b0;
    rank_in   = '0;
    out_ready = 1'b0;
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // rank_in held at 0 after reset: nothing is logged
    for (int i = 0; i < 10; i++) step('0, 1'b0, 1'b0);
    check("idle_valid", 64'(out_valid), 64'(0));

    // 0,0,5,5,9 with consumer ready
    step(32'd3, 1'b1, 1'b1);
    step(32'd0, 1'b1, 1'b0);
    step(32'd0, 1'b1, 1'b0);
    step(32'd5, 1'b1, 1'b0);
    check("rec5_value", 64'(out_value), 64'(5));
    check("rec5_stamp", 64'(out_stamp), 64'(2));
    step(32'd5, 1'b1, 1'b0);
    step(32'd9, 1'b1, 1'b0);
    check("rec9_value", 64'(out_value), 64'(9));
    check("rec9_stamp", 64'(out_stamp), 64'(4));
    step(32'd9, 1'b1, 1'b0);

    // overflow: ten changes into an eight-deep FIFO, then drain in order
    step(32'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step(DW'(k), 1'b0, 1'b0);
      if (k == 8) check("full_after_8", 64'(full), 64'(1));
    end
    check("drop_after_10", 64'(drop_count), 64'(2));
    for (int k = 1; k <= 8; k++) begin
      check("drain_order", 64'(out_value), 64'(k));
      step(32'd10, 1'b1, 1'b0);
    end
    check("drained_valid", 64'(out_valid), 64'(0));

    // full FIFO: push and pop on the same edge is lossless
    step(32'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) step(DW'(k), 1'b0, 1'b0);
    step(32'd20, 1'b1, 1'b0);
    check("pp_full", 64'(full), 64'(1));
    check("pp_drop", 64'(drop_count), 64'(0));
    check("pp_head", 64'(out_value), 64'(2));

    // clear with records queued and drops counted
    step(32'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 11; k++) step(DW'(k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(32'd11, 1'b1, 1'b0);
    check("preclr_drop", 64'(drop_count), 64'(3));
    step(32'd11, 1'b1, 1'b1);
    check("clr_valid", 64'(out_valid), 64'(0));
    check("clr_drop", 64'(drop_count), 64'(0));
    step(32'd0, 1'b0, 1'b0);
    step(32'd7, 1'b0, 1'b0);
    check("postclr_value", 64'(out_value), 64'(7));
    check("postclr_stamp", 64'(out_stamp), 64'(1));

    // timestamp wrap
    step(32'd0, 1'b1, 1'b1);
    for (int k = 0; k < 15; k++) step(32'd0, 1'b1, 1'b0);
    step(32'd3, 1'b1, 1'b0);
    check("wrap_stamp15", 64'(out_stamp), 64'(15));
    step(32'd3, 1'b1, 1'b0);
    step(32'd4, 1'b1, 1'b0);
    check("wrap_stamp1", 64'(out_stamp), 64'(1));

    // drop counter saturation
    step(32'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 13; k++) step(DW'(k), 1'b0, 1'b0);
    check("drop_sat", 64'(drop_count), 64'(3));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 2));
      step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
    end

    // asynchronous reset in mid-cycle
    for (int k = 1; k <= 4; k++) step(DW'(k + 100), 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(32'd0, 1'b1, 1'b0);
    step(32'd42, 1'b1, 1'b0);
    check("after_reset_value", 64'(out_value), 64'(42));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rank_change_logger.md
Name: rank_change_logger

Overview:
- Sits directly downstream of the running second-largest tracker.
- Samples the tracker's output every cycle and detects changes in value.
- Each change is pushed as a {value, timestamp} record into a small first-word-fall-through FIFO, drained by a valid/ready consumer (debug/trace port).
- Overflow is counted, never stalls the tracker, and a synchronous clear restarts logging in step with a tracker restart.

Parameters:
DATA_WIDTH, 32, width of the tracked value (matches tracker dout)
STAMP_WIDTH, 16, width of free-running cycle timestamp
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_WIDTH, 8, width of saturating drop counter

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear; pulse when the tracker restarts
rank_in  input  DATA_WIDTH  tracker second-largest output, sampled every cycle
out_valid  output  1  head record available
out_ready  input  1  consumer accepts head record
out_value  output  DATA_WIDTH  head record value
out_stamp  output  STAMP_WIDTH  head record timestamp
full  output  1  FIFO holds DEPTH records
drop_count  output  CNT_WIDTH  records lost to overflow, saturating

Behaviour:
- Reset (resetn low, async):
  - FIFO empty; out_valid=0, full=0.
  - out_value and out_stamp = 0.
  - drop_count=0; internal prev=0; stamp counter=0.
- Stamp counter:
  - +1 every clk edge with clr=0; wraps 2^STAMP_WIDTH-1 -> 0.
  - clr=1: loads 0.
- Event detect:
  - event = !clr && (rank_in != prev).
  - prev <= rank_in every edge with clr=0; prev <= 0 on clr.
  - A rank_in of 0 after reset is therefore not an event.
- Record contents:
  - value = rank_in at the sampling edge.
  - stamp = counter value before that edge's increment.
- Latency: a record pushed at edge N is visible at out_* from edge N onward. out_valid rises one cycle after rank_in changes.
- FIFO behaviour:
  - FWFT: out_valid = !empty; out_value/out_stamp show the head.
  - out_value/out_stamp are 0 while empty.
  - Pop when out_valid && out_ready.
  - Push accepted if !full, or if full and a pop occurs in the same cycle (simultaneous push+pop when full is lossless).
  - Simultaneous push+pop when empty: push only. Pop is illegal because out_valid=0.
  - full = (count == DEPTH); count stays within 0..DEPTH.
- Overflow:
  - event while full and no pop: record discarded, FIFO unchanged.
  - drop_count +1, saturating at 2^CNT_WIDTH-1.
  - prev still updates, so the next record reflects the new value and no duplicate is generated.
- clr (sync, highest priority after reset):
  - FIFO flushed; out_valid=0 next cycle.
  - drop_count=0, prev=0, stamp=0.
  - Any event or pop in the clr cycle is ignored.
- out_ready toggling while out_valid=1 is legal. The head is stable until popped or cleared.
- No combinational path from rank_in to outputs. out_valid and full are register-derived.

Test Plan:
- Reset, then rank_in held 0 for 10 cycles -> out_valid stays 0, drop_count=0.
- out_ready=1; rank_in 0,0,5,5,9 on cycles 0-4 -> records (5,stamp 2), then (9,stamp 4). Each out_valid rises one cycle after its change.
- DEPTH=8, out_ready=0; rank_in changes on 10 consecutive cycles (1..10) -> full=1 after 8; drop_count=2; draining yields values 1..8 in order.
- Full FIFO, out_ready=1, rank_in changes the same cycle -> pop and push both occur; full stays 1; drop_count unchanged.
- 5 records queued and drop_count=3, then clr pulse -> next cycle out_valid=0, drop_count=0. Next change to 7 at 2 cycles after clr -> record (7, stamp 1).
- STAMP_WIDTH=4; change at counter 15, next change two cycles later -> stamps 15 then 1 (wrap). drop_count saturation checked with CNT_WIDTH=2: 5 drops -> 3.
